// File: rtl/linear_bgrad_acc.sv
// Linear-layer bias gradient: dB[j] = sum_i dY[i][j], optionally seeded with dB[j] from memory.
// Q16.16 fixed point. At most one memory access is outstanding at any time.
module linear_bgrad_acc #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned BATCH_W  = 16,
  parameter bit          SATURATE = 1'b1
) (
  input  logic               clk,
  input  logic               rst_l,
  input  logic               go,
  input  logic               acc_mode,
  input  logic [BATCH_W-1:0] batch_size,
  input  logic [ADDR_W-1:0]  src_begin,
  input  logic [ADDR_W-1:0]  dst_begin,
  input  logic [ADDR_W-1:0]  dst_end,
  output logic               rd_en,
  output logic [ADDR_W-1:0]  rd_addr,
  input  logic [DATA_W-1:0]  rd_data,
  input  logic               rd_done,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [DATA_W-1:0]  wr_data,
  output logic               wr_through,
  input  logic               wr_done,
  output logic               done,
  output logic               err,
  output logic               ovf
);

  typedef enum logic [2:0] {IDLE, CHECK, INIT, LOAD, WRITE, DONE} state_t;

  localparam logic [DATA_W-1:0] MAX_POS = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MAX_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  state_t              state;
  logic                acc_mode_q;
  logic [BATCH_W-1:0]  batch_q;
  logic [BATCH_W-1:0]  row_idx;
  logic [ADDR_W-1:0]   src_q;
  logic [ADDR_W-1:0]   dst_begin_q;
  logic [ADDR_W-1:0]   dst_end_q;
  logic [ADDR_W-1:0]   features;
  logic [ADDR_W-1:0]   col_idx;
  logic [ADDR_W-1:0]   col_addr;
  logic [ADDR_W-1:0]   row_addr;
  logic [DATA_W-1:0]   acc;

  logic [DATA_W:0]     sum_c;
  logic [DATA_W-1:0]   sum_res_c;
  logic                sum_ovf_c;
  logic                last_row_c;
  logic                last_col_c;

  // Sign-extended add; overflow when the two top bits of the wide sum disagree.
  always_comb begin
    sum_c     = {acc[DATA_W-1], acc} + {rd_data[DATA_W-1], rd_data};
    sum_ovf_c = sum_c[DATA_W] ^ sum_c[DATA_W-1];
    sum_res_c = sum_c[DATA_W-1:0];
    if (SATURATE && sum_ovf_c) begin
      sum_res_c = sum_c[DATA_W] ? MAX_NEG : MAX_POS;
    end
  end

  assign last_row_c = (row_idx == batch_q - BATCH_W'(1));
  assign last_col_c = (col_idx == features - ADDR_W'(1));

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state       <= IDLE;
      acc_mode_q  <= 1'b0;
      batch_q     <= '0;
      row_idx     <= '0;
      src_q       <= '0;
      dst_begin_q <= '0;
      dst_end_q   <= '0;
      features    <= '0;
      col_idx     <= '0;
      col_addr    <= '0;
      row_addr    <= '0;
      acc         <= '0;
      rd_en       <= 1'b0;
      rd_addr     <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      wr_through  <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      ovf         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (go) begin
            acc_mode_q  <= acc_mode;
            batch_q     <= batch_size;
            src_q       <= src_begin;
            dst_begin_q <= dst_begin;
            dst_end_q   <= dst_end;
            err         <= 1'b0;
            ovf         <= 1'b0;
            state       <= CHECK;
          end
        end

        CHECK: begin
          features <= dst_end_q - dst_begin_q;
          col_idx  <= '0;
          col_addr <= src_q;
          row_addr <= src_q;
          row_idx  <= '0;
          acc      <= '0;
          if (batch_q == '0 || dst_end_q <= dst_begin_q) begin
            err   <= 1'b1;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            state <= acc_mode_q ? INIT : LOAD;
          end
        end

        // Seed the accumulator with the existing dB[j].
        INIT: begin
          if (!rd_en) begin
            rd_en   <= 1'b1;
            rd_addr <= dst_begin_q + col_idx;
          end else if (rd_done) begin
            rd_en <= 1'b0;
            acc   <= rd_data;
            state <= LOAD;
          end
        end

        LOAD: begin
          if (!rd_en) begin
            rd_en   <= 1'b1;
            rd_addr <= row_addr;
          end else if (rd_done) begin
            rd_en    <= 1'b0;
            acc      <= sum_res_c;
            row_addr <= row_addr + features;
            row_idx  <= row_idx + BATCH_W'(1);
            if (sum_ovf_c) begin
              ovf <= 1'b1;
            end
            if (last_row_c) begin
              state <= WRITE;
            end
          end
        end

        WRITE: begin
          if (!wr_en) begin
            wr_en      <= 1'b1;
            wr_addr    <= dst_begin_q + col_idx;
            wr_data    <= acc;
            wr_through <= last_col_c;
          end else if (wr_done) begin
            wr_en      <= 1'b0;
            wr_through <= 1'b0;
            if (last_col_c) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              col_idx  <= col_idx + ADDR_W'(1);
              col_addr <= col_addr + ADDR_W'(1);
              row_addr <= col_addr + ADDR_W'(1);
              row_idx  <= '0;
              acc      <= '0;
              state    <= acc_mode_q ? INIT : LOAD;
            end
          end
        end

        DONE: begin
          if (!go) begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_linear_bgrad_acc.sv
// Bench for linear_bgrad_acc: two instances (saturating / wrapping), each with its own memory model.
// Expected reads and writes are queued at launch and matched as the DUT completes accesses.
module tb_linear_bgrad_acc;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned BW = 16;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          thr;
  } wr_exp_t;

  logic          clk = 1'b0;
  logic          rst_l = 1'b0;
  logic          acc_mode;
  logic [BW-1:0] batch_size;
  logic [AW-1:0] src_begin, dst_begin, dst_end;

  logic          go [2];
  logic          rd_en [2];
  logic          rd_done [2];
  logic          wr_en [2];
  logic          wr_done [2];
  logic          wr_through [2];
  logic          done [2];
  logic          err [2];
  logic          ovf [2];
  logic [AW-1:0] rd_addr [2];
  logic [AW-1:0] wr_addr [2];
  logic [DW-1:0] rd_data [2];
  logic [DW-1:0] wr_data [2];

  logic [DW-1:0] mem [2][64];
  logic [AW-1:0] exp_rd [2][$];
  wr_exp_t       exp_wr [2][$];
  bit            any_req [2];
  bit            both_req [2];
  int            lat;
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  for (genvar k = 0; k < 2; k++) begin : g_dut
    int cnt_r;
    int cnt_w;

    linear_bgrad_acc #(
      .DATA_W  (DW),
      .ADDR_W  (AW),
      .BATCH_W (BW),
      .SATURATE(k == 0)
    ) u_dut (
      .clk       (clk),
      .rst_l     (rst_l),
      .go        (go[k]),
      .acc_mode  (acc_mode),
      .batch_size(batch_size),
      .src_begin (src_begin),
      .dst_begin (dst_begin),
      .dst_end   (dst_end),
      .rd_en     (rd_en[k]),
      .rd_addr   (rd_addr[k]),
      .rd_data   (rd_data[k]),
      .rd_done   (rd_done[k]),
      .wr_en     (wr_en[k]),
      .wr_addr   (wr_addr[k]),
      .wr_data   (wr_data[k]),
      .wr_through(wr_through[k]),
      .wr_done   (wr_done[k]),
      .done      (done[k]),
      .err       (err[k]),
      .ovf       (ovf[k])
    );

    // Memory responder: completion pulse after `lat` extra cycles.
    always @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
        rd_done[k] <= 1'b0;
        wr_done[k] <= 1'b0;
        rd_data[k] <= '0;
        cnt_r      <= 0;
        cnt_w      <= 0;
      end else begin
        rd_done[k] <= 1'b0;
        wr_done[k] <= 1'b0;
        if (rd_en[k] && !rd_done[k]) begin
          if (cnt_r >= lat) begin
            rd_done[k] <= 1'b1;
            rd_data[k] <= mem[k][rd_addr[k][5:0]];
            cnt_r      <= 0;
          end else begin
            cnt_r <= cnt_r + 1;
          end
        end
        if (wr_en[k] && !wr_done[k]) begin
          if (cnt_w >= lat) begin
            wr_done[k] <= 1'b1;
            cnt_w      <= 0;
          end else begin
            cnt_w <= cnt_w + 1;
          end
        end
      end
    end

    // Scoreboard side: match completed accesses against the queued expectations.
    always @(negedge clk) begin
      if (rst_l) begin
        if (rd_en[k] || wr_en[k]) any_req[k] = 1'b1;
        if (rd_en[k] && wr_en[k]) both_req[k] = 1'b1;
        if (rd_en[k] && rd_done[k]) begin
          if (exp_rd[k].size() == 0) check("rd_extra", 64'(exp_rd[k].size()), 64'd1);
          else check("rd_addr", 64'(rd_addr[k]), 64'(exp_rd[k].pop_front()));
        end
        if (wr_en[k] && wr_done[k]) begin
          mem[k][wr_addr[k][5:0]] = wr_data[k];
          if (exp_wr[k].size() == 0) begin
            check("wr_extra", 64'(exp_wr[k].size()), 64'd1);
          end else begin
            wr_exp_t e;
            e = exp_wr[k].pop_front();
            check("wr_addr", 64'(wr_addr[k]), 64'(e.addr));
            check("wr_data", 64'(wr_data[k]), 64'(e.data));
            check("wr_through", 64'(wr_through[k]), 64'(e.thr));
          end
        end
      end
    end
  end

  // Reference model: queue expected accesses and drive the configuration inputs.
  task automatic plan(input int k, input bit mode, input int bs, input int src, input int dst,
                      input int feat, output bit eerr, output bit eovf);
    logic [DW-1:0] a;
    logic [DW-1:0] v;
    longint        t;
    wr_exp_t       e;
    eovf = 1'b0;
    eerr = (bs == 0) || (feat <= 0);
    if (!eerr) begin
      for (int j = 0; j < feat; j++) begin
        a = '0;
        if (mode) begin
          exp_rd[k].push_back(AW'(dst + j));
          a = mem[k][dst + j];
        end
        for (int i = 0; i < bs; i++) begin
          exp_rd[k].push_back(AW'(src + i * feat + j));
          v = mem[k][src + i * feat + j];
          t = longint'($signed(a)) + longint'($signed(v));
          if (t > 64'sh7FFF_FFFF || t < -64'sh8000_0000) begin
            eovf = 1'b1;
            if (k == 0) a = (t > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
            else        a = 32'(t);
          end else begin
            a = 32'(t);
          end
        end
        e.addr = AW'(dst + j);
        e.data = a;
        e.thr  = (j == feat - 1);
        exp_wr[k].push_back(e);
      end
    end
    acc_mode    = mode;
    batch_size  = BW'(bs);
    src_begin   = AW'(src);
    dst_begin   = AW'(dst);
    dst_end     = AW'(dst + feat);
    any_req[k]  = 1'b0;
    both_req[k] = 1'b0;
  endtask

  task automatic run_op(input int k, input bit mode, input int bs, input int src, input int dst,
                        input int feat, input bit drop_go, input string tag);
    bit eerr;
    bit eovf;
    int cyc;
    plan(k, mode, bs, src, dst, feat, eerr, eovf);
    go[k] = 1'b1;
    cyc = 0;
    while (done[k] !== 1'b1 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (drop_go && cyc == 4) go[k] = 1'b0;
    end
    check({tag, "_done"}, 64'(done[k]), 64'd1);
    check({tag, "_err"}, 64'(err[k]), 64'(eerr));
    check({tag, "_ovf"}, 64'(ovf[k]), 64'(eovf));
    check({tag, "_rd_left"}, 64'(exp_rd[k].size()), 64'd0);
    check({tag, "_wr_left"}, 64'(exp_wr[k].size()), 64'd0);
    check({tag, "_rdwr_overlap"}, 64'(both_req[k]), 64'd0);
    if (eerr) begin
      check({tag, "_err_latency_ok"}, 64'(cyc <= 3), 64'd1);
      check({tag, "_no_access"}, 64'(any_req[k]), 64'd0);
    end
    exp_rd[k].delete();
    exp_wr[k].delete();
    go[k] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check({tag, "_done_clr"}, 64'(done[k]), 64'd0);
    check({tag, "_err_hold"}, 64'(err[k]), 64'(eerr));
  endtask

  initial begin
    bit eerr;
    bit eovf;
    int cyc;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 64; i++) mem[k][i] = '0;
      go[k] = 1'b0;
      any_req[k] = 1'b0;
      both_req[k] = 1'b0;
    end
    acc_mode = 1'b0;
    batch_size = '0;
    src_begin = '0;
    dst_begin = '0;
    dst_end = '0;
    lat = 0;

    repeat (3) @(negedge clk);
    check("rst_ctrl", 64'({rd_en[0], wr_en[0], wr_through[0], done[0], err[0], ovf[0]}), 64'd0);
    check("rst_wr_data", 64'(wr_data[0]), 64'd0);
    rst_l = 1'b1;
    @(negedge clk);

    // Copy: batch 1, four features.
    mem[0][8]  = 32'h0001_0000;
    mem[0][9]  = 32'h0002_0000;
    mem[0][10] = 32'hFFFF_0000;
    mem[0][11] = 32'h0000_0000;
    mem[0][51] = 32'hDEAD_BEEF;
    run_op(0, 1'b0, 1, 8, 48, 4, 1'b0, "copy");
    check("copy_d0", 64'(mem[0][48]), 64'h0001_0000);
    check("copy_d2", 64'(mem[0][50]), 64'hFFFF_0000);
    check("copy_d3", 64'(mem[0][51]), 64'h0);

    // Sum over three rows, two features.
    lat = 1;
    for (int i = 0; i < 6; i++) mem[0][i] = DW'(i + 1);
    run_op(0, 1'b0, 3, 0, 32, 2, 1'b0, "sum");
    check("sum_d0", 64'(mem[0][32]), 64'd9);
    check("sum_d1", 64'(mem[0][33]), 64'd12);

    // Reset while reading rows of the first column, then rerun.
    mem[0][32] = '0;
    mem[0][33] = '0;
    plan(0, 1'b0, 3, 0, 32, 2, eerr, eovf);
    go[0] = 1'b1;
    cyc = 0;
    while (!(rd_en[0] && rd_done[0]) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    while (!rd_en[0] && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    check("rst_mid_reached", 64'(rd_en[0]), 64'd1);
    rst_l = 1'b0;
    #1;
    check("rst_mid_ctrl", 64'({rd_en[0], wr_en[0], wr_through[0], done[0], err[0], ovf[0]}), 64'd0);
    check("rst_mid_rd_addr", 64'(rd_addr[0]), 64'd0);
    check("rst_mid_wr_addr", 64'(wr_addr[0]), 64'd0);
    go[0] = 1'b0;
    exp_rd[0].delete();
    exp_wr[0].delete();
    @(negedge clk);
    check("rst_mid_no_write", 64'(mem[0][32]), 64'd0);
    rst_l = 1'b1;
    @(negedge clk);
    run_op(0, 1'b0, 3, 0, 32, 2, 1'b0, "sum_again");
    check("sum2_d0", 64'(mem[0][32]), 64'd9);
    check("sum2_d1", 64'(mem[0][33]), 64'd12);

    // Accumulate onto preloaded dB.
    mem[0][32] = 32'd100;
    mem[0][33] = 32'd200;
    run_op(0, 1'b1, 3, 0, 32, 2, 1'b0, "acc");
    check("acc_d0", 64'(mem[0][32]), 64'd109);
    check("acc_d1", 64'(mem[0][33]), 64'd212);

    // Positive overflow: saturating instance 0, wrapping instance 1.
    lat = 0;
    for (int k = 0; k < 2; k++) begin
      mem[k][16] = 32'h7FFF_0000;
      mem[k][17] = 32'h0002_0000;
    end
    run_op(0, 1'b0, 2, 16, 56, 1, 1'b0, "ovf_sat");
    check("ovf_sat_val", 64'(mem[0][56]), 64'h7FFF_FFFF);
    run_op(1, 1'b0, 2, 16, 56, 1, 1'b0, "ovf_wrap");
    check("ovf_wrap_val", 64'(mem[1][56]), 64'h8001_0000);

    // Invalid configurations.
    run_op(0, 1'b0, 0, 0, 40, 2, 1'b0, "bad_batch");
    run_op(0, 1'b1, 3, 0, 40, 0, 1'b0, "bad_empty");
    run_op(0, 1'b0, 3, 0, 40, -2, 1'b0, "bad_reversed");

    // go dropped mid-operation; also ovf must be cleared by the new start.
    lat = 2;
    run_op(0, 1'b0, 1, 8, 40, 4, 1'b1, "drop_go");
    check("drop_go_d1", 64'(mem[0][41]), 64'h0002_0000);
    check("drop_go_d2", 64'(mem[0][42]), 64'hFFFF_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
